tl_source_arbiter: RTL and testbench
====================================

# tl_source_arbiter

Merges N TileLink-UL client ports onto one master port, which feeds the crossbar input. The A channel uses round-robin arbitration with a burst lock. Each client's source ID is prefixed with its port index, and D responses are routed back by that prefix. The block also enforces a per-client outstanding-request limit.

## Interface
- `N`, 2: number of client ports, 2..8; `IDXW = $clog2(N)`.
- `SRC_W`, 6: client source width; master source width is `SRC_W+IDXW`.
- `ADDR_W`, 21: address width.
- `DATA_W`, 64: data width; one beat carries 8 bytes.
- `MAX_INFLIGHT`, 4: maximum outstanding requests per client, 1..15.
- `clock`  in  1  single clock.
- `reset`  in  1  synchronous, active-low (block is in reset while 0).
- `in_a_valid` / `in_a_ready`  in / out  N  per-client A handshake.
- `in_a_bits_{opcode,param,size}`  in  3N  packed, client i at `[3i+:3]`.
- `in_a_bits_source`  in  SRC_W*N; `in_a_bits_address`  in  ADDR_W*N; `in_a_bits_mask`  in  8N; `in_a_bits_data`  in  DATA_W*N; `in_a_bits_corrupt`  in  N.
- `in_d_valid` / `in_d_ready`  out / in  N  per-client D handshake.
- `in_d_bits_{opcode,size}`  out  3: broadcast to all clients.
- `in_d_bits_source`  out  SRC_W: broadcast.
- `in_d_bits_data`  out  DATA_W: broadcast.
- `out_a_valid` / `out_a_ready`  out / in  1  master A handshake.
- `out_a_bits_*`  out  same widths as one client field; `source` is SRC_W+IDXW.
- `out_d_valid` / `out_d_ready`  in / out  1  master D handshake.
- `out_d_bits_{opcode,size,source,data}`  in  3 / 3 / SRC_W+IDXW / DATA_W.
- `d_route_err`  out  1  sticky flag: a D beat arrived for a prefix ≥ N.

## Operation
- **Beats per message.**
  - A carries data when opcode is PutFull (0) or PutPartial (1).
  - D carries data when opcode is AccessAckData (1).
  - For a message with data, `beats = size>3 ? 1<<(size-3) : 1`, so size 6 gives 8 beats.
  - Every other message is 1 beat.
- **A state.**
  - `a_beats_left` (3 bits): remaining beats of the locked burst.
  - `a_owner` (IDXW bits): client holding the lock.
  - `rr_last` (IDXW bits): last client granted.
- **A idle** (`a_beats_left==0`):
  - A client is eligible when `in_a_valid[i]` is high and `inflight[i] < MAX_INFLIGHT`.
  - Grant goes to the first eligible client after `rr_last`, searching cyclically.
  - `out_a_valid` equals "any eligible".
  - `in_a_ready[g] = out_a_ready`; every other `in_a_ready` is 0.
- **A fire** (valid & ready):
  - `rr_last <= g`.
  - For a multi-beat burst: `a_owner <= g` and `a_beats_left <= beats-1`.
- **A locked** (`a_beats_left!=0`):
  - Only `a_owner` is forwarded. The inflight limit is ignored for continuation beats.
  - Each fire decrements `a_beats_left`.
- **A field mapping.** Output fields are the granted client's fields; `out_a_bits_source = {g, in_a_bits_source[g]}`.
- **Inflight counters** (4 bits each, one per client):
  - +1 on the first beat of an A message.
  - −1 on the last beat of a D message routed to that client.
  - When both happen in the same cycle, the count is unchanged.
- **D routing.**
  - `k = out_d_bits_source[SRC_W+:IDXW]`.
  - `in_d_valid[k] = out_d_valid`; `out_d_ready = in_d_ready[k]`.
  - `in_d_bits_source` is the low SRC_W bits of `out_d_bits_source`.
  - A per-block `d_beats_left` (3 bits) detects the last beat of a multi-beat response.
- **D route error** (`k ≥ N`): `out_d_ready=1`, the beat is dropped, and `d_route_err` is set. Only reset clears it.
- **Reset** (`reset==0`):
  - All counters, `a_beats_left` and `d_beats_left` go to 0.
  - `rr_last` goes to N-1, so client 0 has first priority.
  - `d_route_err` goes to 0.
  - `out_a_valid`, every `in_a_ready`, every `in_d_valid` and `out_d_ready` are forced to 0 while reset is asserted.
- **Reset mid-burst** abandons the burst. The first cycle after reset is idle.

## Timing
- A and D paths are combinational pass-through: zero-cycle latency, no buffering.
- Grant is combinational in the idle cycle. All state updates on the rising edge of `clock`.
- Lock takes effect in the cycle after the first beat fires.
- Switching to a different client needs no extra cycle: back-to-back single-beat grants to different clients are allowed on consecutive cycles.
- A client whose counter reaches `MAX_INFLIGHT` on edge t is ineligible from cycle t+1.
- A D last beat on edge t makes the client eligible again in cycle t+1.
- `out_a_valid` never depends on `out_a_ready`.

## Structure
- Package `tl_arb_pkg` holds:
  - opcode constants (`PUT_FULL`, `PUT_PARTIAL`, `GET`, `ACCESS_ACK`, `ACCESS_ACK_DATA`);
  - `BEAT_BYTES=8`;
  - `function has_data_a/has_data_d`;
  - `function num_beats(size)`.
- Sub-module `rr_arbiter #(N)`: inputs `req[N]` and `last`; output one-hot `gnt[N]` plus `gnt_idx`. Purely combinational.

## Test plan
- **Simultaneous requests:** clients 0 and 1 both issue single-beat Gets every cycle with `out_a_ready=1` → grants alternate 0,1,0,1; `out_a_bits_source` alternates `{0,src}`, `{1,src}`.
- **Burst lock:** client 1 sends PutFull size 6 (8 beats) while client 0 requests → 8 consecutive client-1 beats, then client 0 is granted; beat 4 is stalled by `out_a_ready=0` and the lock holds.
- **Inflight limit:** `MAX_INFLIGHT=4`, client 0 issues 5 Gets with no D → the 5th is not accepted. A D AccessAck with source `{0,x}` frees it, and it is accepted the next cycle.
- **Multi-beat D:** an AccessAckData size 5 (4 beats) to client 1, with `in_d_ready[1]` toggling → `in_d_valid[1]` only; the counter decrements once, after the 4th beat.
- **Route error:** with N=3, a D beat arrives with prefix 3 → `out_d_ready=1`, no `in_d_valid`, and `d_route_err` is set and stays set until reset.
- **Reset mid-burst:** `reset=0` on beat 3 of 8 → all outputs 0 during reset; afterwards client 0 wins a fresh request and `a_beats_left=0`.

Source files
------------

// File: rtl/tl_arb_pkg.sv
// tl_arb_pkg: TileLink-UL opcodes and beat-count helpers shared by the source arbiter.
package tl_arb_pkg;
   localparam logic [2:0] PUT_FULL        = 3'd0;
   localparam logic [2:0] PUT_PARTIAL     = 3'd1;
   localparam logic [2:0] GET             = 3'd4;
   localparam logic [2:0] ACCESS_ACK      = 3'd0;
   localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;
   localparam int BEAT_BYTES = 8;
   localparam int BEAT_LG    = $clog2(BEAT_BYTES);

   function automatic logic has_data_a(input logic [2:0] op);
      return op == PUT_FULL || op == PUT_PARTIAL;
   endfunction

   function automatic logic has_data_d(input logic [2:0] op);
      return op == ACCESS_ACK_DATA;
   endfunction

   function automatic logic [4:0] num_beats(input logic [2:0] size);
      return int'(size) > BEAT_LG ? 5'(1 << (int'(size) - BEAT_LG)) : 5'd1;
   endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester after `last`.
module rr_arbiter #(
   parameter  int N    = 2,
   localparam int IDXW = $clog2(N)
) (
   input  logic [N-1:0]    req,
   input  logic [IDXW-1:0] last,
   output logic [N-1:0]    gnt,
   output logic [IDXW-1:0] gnt_idx
);
   logic [IDXW-1:0] j;

   // Scan farthest-first so the nearest requester after `last` is written last and wins.
   always_comb begin
      gnt = '0;
      gnt_idx = '0;
      j = '0;
      for (int i = N; i >= 1; i--) begin
         j = IDXW'((int'(last) + i) % N);
         if (req[j]) begin
            gnt = '0;
            gnt[j] = 1'b1;
            gnt_idx = j;
         end
      end
   end
endmodule

// File: rtl/tl_source_arbiter.sv
// tl_source_arbiter: merges N TileLink-UL clients onto one master port with
// round-robin A arbitration, burst lock, source prefixing and D routing.
module tl_source_arbiter
   import tl_arb_pkg::*;
#(
   parameter  int N            = 2,
   parameter  int SRC_W        = 6,
   parameter  int ADDR_W       = 21,
   parameter  int DATA_W       = 64,
   parameter  int MAX_INFLIGHT = 4,
   localparam int IDXW         = $clog2(N)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [N-1:0]          in_a_valid,
   output logic [N-1:0]          in_a_ready,
   input  logic [3*N-1:0]        in_a_bits_opcode,
   input  logic [3*N-1:0]        in_a_bits_param,
   input  logic [3*N-1:0]        in_a_bits_size,
   input  logic [SRC_W*N-1:0]    in_a_bits_source,
   input  logic [ADDR_W*N-1:0]   in_a_bits_address,
   input  logic [8*N-1:0]        in_a_bits_mask,
   input  logic [DATA_W*N-1:0]   in_a_bits_data,
   input  logic [N-1:0]          in_a_bits_corrupt,
   output logic [N-1:0]          in_d_valid,
   input  logic [N-1:0]          in_d_ready,
   output logic [2:0]            in_d_bits_opcode,
   output logic [2:0]            in_d_bits_size,
   output logic [SRC_W-1:0]      in_d_bits_source,
   output logic [DATA_W-1:0]     in_d_bits_data,
   output logic                  out_a_valid,
   input  logic                  out_a_ready,
   output logic [2:0]            out_a_bits_opcode,
   output logic [2:0]            out_a_bits_param,
   output logic [2:0]            out_a_bits_size,
   output logic [SRC_W+IDXW-1:0] out_a_bits_source,
   output logic [ADDR_W-1:0]     out_a_bits_address,
   output logic [7:0]            out_a_bits_mask,
   output logic [DATA_W-1:0]     out_a_bits_data,
   output logic                  out_a_bits_corrupt,
   input  logic                  out_d_valid,
   output logic                  out_d_ready,
   input  logic [2:0]            out_d_bits_opcode,
   input  logic [2:0]            out_d_bits_size,
   input  logic [SRC_W+IDXW-1:0] out_d_bits_source,
   input  logic [DATA_W-1:0]     out_d_bits_data,
   output logic                  d_route_err
);
   logic [2:0]        a_op [N], a_param [N], a_size [N];
   logic [SRC_W-1:0]  a_src [N];
   logic [ADDR_W-1:0] a_addr [N];
   logic [7:0]        a_mask [N];
   logic [DATA_W-1:0] a_data [N];
   logic [3:0]        inflight [N];
   logic [2:0]        a_beats_left, d_beats_left;
   logic [IDXW-1:0]   a_owner, rr_last, arb_idx, g, k;
   logic [N-1:0]      eligible, arb_gnt;
   logic [4:0]        a_n, d_n;
   logic              locked, a_fire, d_fire, d_last, route_ok;

   for (genvar i = 0; i < N; i++) begin : g_unpack
      assign a_op[i]   = in_a_bits_opcode[3*i +: 3];
      assign a_param[i] = in_a_bits_param[3*i +: 3];
      assign a_size[i] = in_a_bits_size[3*i +: 3];
      assign a_src[i]  = in_a_bits_source[SRC_W*i +: SRC_W];
      assign a_addr[i] = in_a_bits_address[ADDR_W*i +: ADDR_W];
      assign a_mask[i] = in_a_bits_mask[8*i +: 8];
      assign a_data[i] = in_a_bits_data[DATA_W*i +: DATA_W];
   end

   always_comb begin
      for (int i = 0; i < N; i++) eligible[i] = in_a_valid[i] && inflight[i] < 4'(MAX_INFLIGHT);
   end

   rr_arbiter #(.N(N)) u_rr (.req(eligible), .last(rr_last), .gnt(arb_gnt), .gnt_idx(arb_idx));

   assign locked = a_beats_left != 3'd0;
   assign g = locked ? a_owner : arb_idx;
   assign out_a_valid = reset && (locked ? in_a_valid[a_owner] : |eligible);
   assign a_fire = out_a_valid && out_a_ready;
   assign a_n = has_data_a(a_op[g]) ? num_beats(a_size[g]) : 5'd1;

   assign out_a_bits_opcode  = a_op[g];
   assign out_a_bits_param   = a_param[g];
   assign out_a_bits_size    = a_size[g];
   assign out_a_bits_source  = {g, a_src[g]};
   assign out_a_bits_address = a_addr[g];
   assign out_a_bits_mask    = a_mask[g];
   assign out_a_bits_data    = a_data[g];
   assign out_a_bits_corrupt = in_a_bits_corrupt[g];

   assign k = out_d_bits_source[SRC_W +: IDXW];
   assign route_ok = int'(k) < N;
   assign out_d_ready = reset && (route_ok ? in_d_ready[k] : 1'b1);
   assign d_fire = out_d_valid && out_d_ready;
   assign d_n = has_data_d(out_d_bits_opcode) ? num_beats(out_d_bits_size) : 5'd1;
   assign d_last = d_beats_left == 3'd1 || (d_beats_left == 3'd0 && d_n == 5'd1);
   assign in_d_bits_opcode = out_d_bits_opcode;
   assign in_d_bits_size   = out_d_bits_size;
   assign in_d_bits_source = out_d_bits_source[SRC_W-1:0];
   assign in_d_bits_data   = out_d_bits_data;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         in_a_ready[i] = reset && out_a_ready && (locked ? a_owner == IDXW'(i) : arb_gnt[i]);
         in_d_valid[i] = reset && out_d_valid && route_ok && k == IDXW'(i);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         a_beats_left <= '0;
         d_beats_left <= '0;
         a_owner <= '0;
         rr_last <= IDXW'(N - 1);
         d_route_err <= 1'b0;
         for (int i = 0; i < N; i++) inflight[i] <= '0;
      end else begin
         if (a_fire) rr_last <= g;
         if (a_fire && locked) a_beats_left <= a_beats_left - 3'd1;
         if (a_fire && !locked && a_n > 5'd1) begin
            a_owner <= g;
            a_beats_left <= 3'(a_n - 5'd1);
         end
         if (d_fire) d_beats_left <= d_last ? 3'd0 : d_beats_left == 3'd0 ? 3'(d_n - 5'd1) : d_beats_left - 3'd1;
         if (d_fire && !route_ok) d_route_err <= 1'b1;
         // Only the first A beat and the last D beat of a message move the count.
         for (int i = 0; i < N; i++)
            inflight[i] <= inflight[i] + 4'(a_fire && !locked && g == IDXW'(i))
                                       - 4'(d_fire && d_last && route_ok && k == IDXW'(i));
      end
   end
endmodule

// File: tb/tb_tl_source_arbiter.sv
// tb_tl_source_arbiter: directed stimulus with a message-level model checked every cycle.
module tb_tl_source_arbiter;
   localparam int N = 3, SW = 6, AW = 21, DW = 64, MAXF = 4, MW = SW + 2;

   logic clock = 1'b0;
   logic reset;
   logic [N-1:0]    in_a_valid, in_a_ready, in_a_bits_corrupt, in_d_valid, in_d_ready;
   logic [3*N-1:0]  in_a_bits_opcode, in_a_bits_param, in_a_bits_size;
   logic [SW*N-1:0] in_a_bits_source;
   logic [AW*N-1:0] in_a_bits_address;
   logic [8*N-1:0]  in_a_bits_mask;
   logic [DW*N-1:0] in_a_bits_data;
   logic [2:0]      in_d_bits_opcode, in_d_bits_size;
   logic [SW-1:0]   in_d_bits_source;
   logic [DW-1:0]   in_d_bits_data;
   logic            out_a_valid, out_a_ready, out_a_bits_corrupt;
   logic [2:0]      out_a_bits_opcode, out_a_bits_param, out_a_bits_size;
   logic [MW-1:0]   out_a_bits_source;
   logic [AW-1:0]   out_a_bits_address;
   logic [7:0]      out_a_bits_mask;
   logic [DW-1:0]   out_a_bits_data;
   logic            out_d_valid, out_d_ready;
   logic [2:0]      out_d_bits_opcode, out_d_bits_size;
   logic [MW-1:0]   out_d_bits_source;
   logic [DW-1:0]   out_d_bits_data;
   logic            d_route_err;

   int n_checks = 0, n_errors = 0;
   int m_inf [N];
   int m_rr, m_owner, m_burst, m_dleft;
   bit m_err;

   tl_source_arbiter #(.N(N), .SRC_W(SW), .ADDR_W(AW), .DATA_W(DW), .MAX_INFLIGHT(MAXF)) dut (
      .clock(clock), .reset(reset),
      .in_a_valid(in_a_valid), .in_a_ready(in_a_ready),
      .in_a_bits_opcode(in_a_bits_opcode), .in_a_bits_param(in_a_bits_param),
      .in_a_bits_size(in_a_bits_size), .in_a_bits_source(in_a_bits_source),
      .in_a_bits_address(in_a_bits_address), .in_a_bits_mask(in_a_bits_mask),
      .in_a_bits_data(in_a_bits_data), .in_a_bits_corrupt(in_a_bits_corrupt),
      .in_d_valid(in_d_valid), .in_d_ready(in_d_ready),
      .in_d_bits_opcode(in_d_bits_opcode), .in_d_bits_size(in_d_bits_size),
      .in_d_bits_source(in_d_bits_source), .in_d_bits_data(in_d_bits_data),
      .out_a_valid(out_a_valid), .out_a_ready(out_a_ready),
      .out_a_bits_opcode(out_a_bits_opcode), .out_a_bits_param(out_a_bits_param),
      .out_a_bits_size(out_a_bits_size), .out_a_bits_source(out_a_bits_source),
      .out_a_bits_address(out_a_bits_address), .out_a_bits_mask(out_a_bits_mask),
      .out_a_bits_data(out_a_bits_data), .out_a_bits_corrupt(out_a_bits_corrupt),
      .out_d_valid(out_d_valid), .out_d_ready(out_d_ready),
      .out_d_bits_opcode(out_d_bits_opcode), .out_d_bits_size(out_d_bits_size),
      .out_d_bits_source(out_d_bits_source), .out_d_bits_data(out_d_bits_data),
      .d_route_err(d_route_err)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int beats(input bit data, input int size);
      return (data && size > 3) ? (1 << (size - 3)) : 1;
   endfunction

   // Message-level model: expected outputs from the current inputs, then advance past the edge.
   always @(negedge clock) begin : compare
      int g, c, k, nb;
      bit any, av, dr;
      logic [N-1:0] ar, dv;
      g = 0;
      any = 0;
      if (m_burst > 0) begin
         g = m_owner;
         any = 1;
         av = in_a_valid[g];
      end else begin
         for (int s = 1; s <= N; s++) begin
            c = (m_rr + s) % N;
            if (!any && in_a_valid[c] && m_inf[c] < MAXF) begin
               g = c;
               any = 1;
            end
         end
         av = any;
      end
      av = av && reset;
      ar = '0;
      if (any && reset) ar[g] = out_a_ready;
      k = int'(out_d_bits_source[MW-1:SW]);
      dv = '0;
      dr = 1'b1;
      if (k < N) begin
         dv[k] = out_d_valid;
         dr = in_d_ready[k];
      end
      if (!reset) begin
         dv = '0;
         dr = 1'b0;
      end
      chk("out_a_valid", out_a_valid, av);
      chk("in_a_ready", in_a_ready, ar);
      if (av) begin
         chk("out_a_source", out_a_bits_source, 64'((g << SW) | int'(in_a_bits_source[SW*g +: SW])));
         chk("out_a_opcode", out_a_bits_opcode, in_a_bits_opcode[3*g +: 3]);
         chk("out_a_size", out_a_bits_size, in_a_bits_size[3*g +: 3]);
         chk("out_a_address", out_a_bits_address, in_a_bits_address[AW*g +: AW]);
         chk("out_a_data", out_a_bits_data, in_a_bits_data[DW*g +: DW]);
      end
      chk("in_d_valid", in_d_valid, dv);
      chk("out_d_ready", out_d_ready, dr);
      chk("in_d_source", in_d_bits_source, out_d_bits_source[SW-1:0]);
      chk("d_route_err", d_route_err, m_err);
      if (!reset) begin
         foreach (m_inf[i]) m_inf[i] = 0;
         m_rr = N - 1;
         m_owner = 0;
         m_burst = 0;
         m_dleft = 0;
         m_err = 0;
      end else begin
         if (av && out_a_ready) begin
            if (m_burst > 0) m_burst--;
            else begin
               m_inf[g]++;
               nb = beats(in_a_bits_opcode[3*g +: 3] <= 3'd1, int'(in_a_bits_size[3*g +: 3]));
               if (nb > 1) begin
                  m_owner = g;
                  m_burst = nb - 1;
               end
            end
            m_rr = g;
         end
         if (out_d_valid && dr) begin
            if (m_dleft == 0) m_dleft = beats(out_d_bits_opcode == 3'd1, int'(out_d_bits_size));
            m_dleft--;
            if (k >= N) m_err = 1;
            else if (m_dleft == 0) m_inf[k]--;
         end
      end
   end

   task automatic set_a(input int i, input logic v, input logic [2:0] op, input logic [2:0] sz,
                        input logic [SW-1:0] src, input logic [DW-1:0] data);
      in_a_valid[i] = v;
      in_a_bits_opcode[3*i +: 3] = op;
      in_a_bits_size[3*i +: 3] = sz;
      in_a_bits_source[SW*i +: SW] = src;
      in_a_bits_data[DW*i +: DW] = data;
      in_a_bits_address[AW*i +: AW] = AW'(32'h1_0000 * (i + 1)) ^ data[AW-1:0];
   endtask

   task automatic set_d(input logic v, input logic [2:0] op, input logic [2:0] sz,
                        input logic [MW-1:0] src, input logic [N-1:0] rdy);
      out_d_valid = v;
      out_d_bits_opcode = op;
      out_d_bits_size = sz;
      out_d_bits_source = src;
      out_d_bits_data = {56'h0, src};
      in_d_ready = rdy;
   endtask

   task automatic step();
      @(negedge clock);
      @(posedge clock);
      #1;
   endtask

   task automatic ack(input logic [MW-1:0] src, input int n);
      for (int j = 0; j < n; j++) begin
         set_d(1'b1, 3'd0, 3'd2, src, '1);
         step();
      end
      set_d(1'b0, 3'd0, 3'd0, '0, '1);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: bench did not reach its end");
      $fatal(1);
   end

   initial begin
      logic [5:0] pat;
      reset = 1'b0;
      out_a_ready = 1'b1;
      in_a_valid = '0;
      in_a_bits_opcode = '0;
      in_a_bits_param = '0;
      in_a_bits_size = '0;
      in_a_bits_source = '0;
      in_a_bits_address = '0;
      in_a_bits_mask = '1;
      in_a_bits_data = '0;
      in_a_bits_corrupt = '0;
      set_d(1'b1, 3'd0, 3'd2, 8'h05, '1);
      set_a(0, 1'b1, 3'd4, 3'd2, 6'h05, 64'hA0);
      set_a(1, 1'b1, 3'd4, 3'd2, 6'h0A, 64'hA1);
      // Reset forces every handshake output low even with requests pending.
      @(negedge clock);
      chk("rst_out_a_valid", out_a_valid, 0);
      chk("rst_in_a_ready", in_a_ready, 0);
      chk("rst_out_d_ready", out_d_ready, 0);
      chk("rst_in_d_valid", in_d_valid, 0);
      @(posedge clock);
      #1;
      step();
      reset = 1'b1;
      set_d(1'b0, 3'd0, 3'd0, '0, '1);
      // Two clients contending alternate, client 0 first.
      for (int c = 0; c < 4; c++) begin
         @(negedge clock);
         chk("rr_source", out_a_bits_source, (c % 2) ? 8'h4A : 8'h05);
         chk("rr_ready", in_a_ready, (c % 2) ? 3'b010 : 3'b001);
         @(posedge clock);
         #1;
      end
      set_a(0, 1'b0, 3'd4, 3'd2, 6'h05, 64'h0);
      set_a(1, 1'b0, 3'd4, 3'd2, 6'h0A, 64'h0);
      set_d(1'b1, 3'd0, 3'd2, 8'h4A, '1);
      @(negedge clock);
      chk("d_route_valid", in_d_valid, 3'b010);
      chk("d_route_source", in_d_bits_source, 6'h0A);
      @(posedge clock);
      #1;
      ack(8'h4A, 1);
      ack(8'h05, 2);
      // Burst lock: 8-beat PutFull from client 1 with a stall on beat 4.
      set_a(0, 1'b1, 3'd4, 3'd2, 6'h05, 64'hC0);
      step();
      for (int cy = 0; cy < 10; cy++) begin
         set_a(1, cy < 9, 3'd0, 3'd6, 6'h0A, 64'hB000 + 64'(cy <= 3 ? cy : cy - 1));
         out_a_ready = (cy != 3);
         @(negedge clock);
         if (cy == 3) begin
            chk("lock_stall_ready", in_a_ready, 3'b000);
            chk("lock_stall_src", out_a_bits_source, 8'h4A);
         end
         if (cy == 8) chk("lock_last_data", out_a_bits_data, 64'hB007);
         if (cy == 9) chk("after_lock_src", out_a_bits_source, 8'h05);
         @(posedge clock);
         #1;
      end
      set_a(0, 1'b0, 3'd4, 3'd2, 6'h05, 64'h0);
      out_a_ready = 1'b1;
      ack(8'h05, 2);
      ack(8'h4A, 1);
      // Inflight limit: 5th Get blocked until an ack frees a slot.
      set_a(0, 1'b1, 3'd4, 3'd2, 6'h05, 64'hD0);
      for (int cy = 0; cy < 7; cy++) begin
         if (cy == 5) set_d(1'b1, 3'd0, 3'd2, 8'h05, '1);
         else set_d(1'b0, 3'd0, 3'd0, '0, '1);
         @(negedge clock);
         if (cy == 4) chk("limit_block", out_a_valid, 0);
         if (cy == 5) chk("limit_hold", out_a_valid, 0);
         if (cy == 6) chk("limit_release", out_a_valid, 1);
         @(posedge clock);
         #1;
      end
      set_a(0, 1'b0, 3'd4, 3'd2, 6'h05, 64'h0);
      ack(8'h05, 4);
      // Multi-beat D: saturated client 1 frees only after the 4th data beat.
      set_a(1, 1'b1, 3'd4, 3'd2, 6'h0A, 64'hE0);
      for (int j = 0; j < 4; j++) step();
      pat = 6'b110101;
      for (int cy = 0; cy < 7; cy++) begin
         if (cy < 6) set_d(1'b1, 3'd1, 3'd5, 8'h43, {1'b0, pat[cy], 1'b0});
         else set_d(1'b0, 3'd0, 3'd0, '0, '1);
         @(negedge clock);
         if (cy < 6) chk("dmb_valid", in_d_valid, 3'b010);
         if (cy == 5) chk("dmb_blocked", out_a_valid, 0);
         if (cy == 6) chk("dmb_release", out_a_valid, 1);
         @(posedge clock);
         #1;
      end
      set_a(1, 1'b0, 3'd4, 3'd2, 6'h0A, 64'h0);
      ack(8'h43, 4);
      // Route error: prefix 3 with N=3 is dropped and latched.
      set_d(1'b1, 3'd0, 3'd2, 8'hC1, 3'b000);
      @(negedge clock);
      chk("err_ready", out_d_ready, 1);
      chk("err_valid", in_d_valid, 0);
      chk("err_before", d_route_err, 0);
      @(posedge clock);
      #1;
      set_d(1'b0, 3'd0, 3'd0, '0, '1);
      for (int j = 0; j < 3; j++) begin
         @(negedge clock);
         chk("err_sticky", d_route_err, 1);
         @(posedge clock);
         #1;
      end
      // Reset in the middle of an 8-beat burst.
      set_a(1, 1'b1, 3'd0, 3'd6, 6'h0A, 64'hF0);
      step();
      step();
      reset = 1'b0;
      @(negedge clock);
      chk("mid_rst_valid", out_a_valid, 0);
      chk("mid_rst_ready", in_a_ready, 0);
      @(posedge clock);
      #1;
      reset = 1'b1;
      set_a(0, 1'b1, 3'd4, 3'd2, 6'h05, 64'hF1);
      set_a(1, 1'b1, 3'd4, 3'd2, 6'h0A, 64'hF2);
      @(negedge clock);
      chk("post_rst_src", out_a_bits_source, 8'h05);
      chk("post_rst_ready", in_a_ready, 3'b001);
      chk("post_rst_err", d_route_err, 0);
      @(posedge clock);
      #1;
      @(negedge clock);
      chk("post_rst_next", out_a_bits_source, 8'h4A);
      @(posedge clock);
      #1;
      set_a(0, 1'b0, 3'd4, 3'd2, 6'h05, 64'h0);
      set_a(1, 1'b0, 3'd4, 3'd2, 6'h0A, 64'h0);
      step();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
